fifo_flags: RTL and testbench

Parametrised synchronous FIFO, successor to the lab FIFO. It adds:
- arbitrary (non-power-of-two) depth;
- selectable normal/show-ahead read mode;
- programmable almost-full/almost-empty flags;
- accept-both read/write when full;
- sticky overflow/underflow error flags;
- a synchronous clear.

It buffers K-bit words between a producer and a consumer in the same clock domain.

---
 rtl/fifo_pkg.sv | 14 +
 rtl/fifo_ram.sv | 26 ++
 rtl/fifo_flags.sv | 139 +++++++++++++
 tb/tb_fifo_flags.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the fifo_flags FIFO family.
package fifo_pkg;

    localparam int unsigned FIFO_NORMAL    = 0;
    localparam int unsigned FIFO_SHOWAHEAD = 1;

    // Pointer width for a given depth; never narrower than one bit.
    function automatic int unsigned ptr_width(input int unsigned depth);
        int unsigned w;
        w = $clog2(depth);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// K x N dual-port storage: synchronous write, asynchronous read.
module fifo_ram #(
    parameter int unsigned K  = 8,
    parameter int unsigned N  = 4,
    parameter int unsigned AW = 2
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [K-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [K-1:0]  rdata
);

    logic [K-1:0] mem_q [N];

    // Contents are intentionally not reset; readers are gated by the count.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/fifo_flags.sv
// Synchronous FIFO of arbitrary depth with almost/sticky-error flags,
// synchronous clear and selectable normal/show-ahead read mode.
module fifo_flags
    import fifo_pkg::*;
#(
    parameter int unsigned K         = 8,
    parameter int unsigned N         = 4,
    parameter int unsigned SHOWAHEAD = FIFO_NORMAL,
    parameter int unsigned AF_LVL    = N - 1,
    parameter int unsigned AE_LVL    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 sclr,
    input  logic                 write,
    input  logic                 read,
    input  logic [K-1:0]         din,
    output logic [K-1:0]         dout,
    output logic                 full,
    output logic                 empty,
    output logic                 almost_full,
    output logic                 almost_empty,
    output logic [$clog2(N):0]   D,
    output logic                 ovf,
    output logic                 udf
);

    localparam int unsigned PW = ptr_width(N);
    localparam int unsigned CW = $clog2(N) + 1;

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] d_q, d_d;
    logic          ovf_q, ovf_d;
    logic          udf_q, udf_d;
    logic          wr_acc, rd_acc;
    logic [K-1:0]  ram_rdata;

    // Pointers wrap at N-1 so non-power-of-two depths use every slot.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(N - 1)) ? '0 : p + PW'(1);
    endfunction

    assign full         = (d_q == CW'(N));
    assign empty        = (d_q == '0);
    assign almost_full  = (32'(d_q) >= AF_LVL);
    assign almost_empty = (32'(d_q) <= AE_LVL);
    assign D            = d_q;
    assign ovf          = ovf_q;
    assign udf          = udf_q;

    // A read frees the slot a full-FIFO write needs, so both are taken.
    assign wr_acc = write & (~full | read) & ~sclr;
    assign rd_acc = read & ~empty & ~sclr;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        d_d      = d_q;
        ovf_d    = ovf_q;
        udf_d    = udf_q;
        if (sclr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            d_d      = '0;
            ovf_d    = 1'b0;
            udf_d    = 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr_d = ptr_inc(wr_ptr_q);
            end
            if (rd_acc) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            if (wr_acc && !rd_acc) begin
                d_d = d_q + CW'(1);
            end else if (!wr_acc && rd_acc) begin
                d_d = d_q - CW'(1);
            end
            ovf_d = ovf_q | (write & full & ~read);
            udf_d = udf_q | (read & empty);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            d_q      <= '0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            d_q      <= d_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    fifo_ram #(
        .K  (K),
        .N  (N),
        .AW (PW)
    ) u_ram (
        .clk   (clk),
        .we    (wr_acc),
        .waddr (wr_ptr_q),
        .wdata (din),
        .raddr (rd_ptr_q),
        .rdata (ram_rdata)
    );

    if (SHOWAHEAD == FIFO_SHOWAHEAD) begin : g_showahead
        assign dout = ram_rdata;
    end else begin : g_normal
        logic [K-1:0] dout_q, dout_d;

        always_comb begin
            dout_d = dout_q;
            if (sclr) begin
                dout_d = '0;
            end else if (rd_acc) begin
                dout_d = ram_rdata;
            end
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                dout_q <= '0;
            end else begin
                dout_q <= dout_d;
            end
        end

        assign dout = dout_q;
    end

endmodule

// File: tb/tb_fifo_flags.sv
// Directed bench: normal-mode N=4 instance and show-ahead N=5 instance.
module tb_fifo_flags;

    logic clk;
    logic rst;

    logic       n_sclr, n_write, n_read;
    logic [7:0] n_din, n_dout;
    logic       n_full, n_empty, n_af, n_ae, n_ovf, n_udf;
    logic [2:0] n_d;

    logic       s_sclr, s_write, s_read;
    logic [7:0] s_din, s_dout;
    logic       s_full, s_empty, s_af, s_ae, s_ovf, s_udf;
    logic [3:0] s_d;

    int n_chk;
    int n_bad;

    fifo_flags #(.K(8), .N(4), .SHOWAHEAD(0)) u_norm (
        .clk(clk), .rst(rst), .sclr(n_sclr), .write(n_write), .read(n_read),
        .din(n_din), .dout(n_dout), .full(n_full), .empty(n_empty),
        .almost_full(n_af), .almost_empty(n_ae), .D(n_d), .ovf(n_ovf), .udf(n_udf)
    );

    fifo_flags #(.K(8), .N(5), .SHOWAHEAD(1)) u_sa (
        .clk(clk), .rst(rst), .sclr(s_sclr), .write(s_write), .read(s_read),
        .din(s_din), .dout(s_dout), .full(s_full), .empty(s_empty),
        .almost_full(s_af), .almost_empty(s_ae), .D(s_d), .ovf(s_ovf), .udf(s_udf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_chk++;
        if (obs !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", tag, obs, exp_v);
        end
    endtask

    task automatic n_cyc(input logic w, input logic r, input logic [7:0] d, input logic c);
        n_write = w;
        n_read  = r;
        n_din   = d;
        n_sclr  = c;
        @(posedge clk);
        @(negedge clk);
        n_write = 1'b0;
        n_read  = 1'b0;
        n_sclr  = 1'b0;
    endtask

    task automatic s_cyc(input logic w, input logic r, input logic [7:0] d);
        s_write = w;
        s_read  = r;
        s_din   = d;
        @(posedge clk);
        @(negedge clk);
        s_write = 1'b0;
        s_read  = 1'b0;
    endtask

    initial begin
        logic [7:0] q[$];
        logic [7:0] nxt;
        logic       w, r;

        n_chk = 0;
        n_bad = 0;
        rst = 1'b0;
        n_sclr = 1'b0; n_write = 1'b0; n_read = 1'b0; n_din = '0;
        s_sclr = 1'b0; s_write = 1'b0; s_read = 1'b0; s_din = '0;

        #2;
        chk("rst_d", 32'(n_d), 0);
        chk("rst_empty", 32'(n_empty), 1);
        chk("rst_full", 32'(n_full), 0);
        chk("rst_ae", 32'(n_ae), 1);
        chk("rst_af", 32'(n_af), 0);
        chk("rst_ovf", 32'(n_ovf), 0);
        chk("rst_udf", 32'(n_udf), 0);
        chk("rst_dout", 32'(n_dout), 0);
        chk("rst_sa_empty", 32'(s_empty), 1);
        @(negedge clk);
        rst = 1'b1;

        // fill and overfill
        for (int i = 1; i <= 4; i++) begin
            n_cyc(1'b1, 1'b0, 8'(i), 1'b0);
            chk("fill_d", 32'(n_d), 32'(i));
            chk("fill_full", 32'(n_full), (i == 4) ? 1 : 0);
            chk("fill_af", 32'(n_af), (i >= 3) ? 1 : 0);
            chk("fill_empty", 32'(n_empty), 0);
        end
        n_cyc(1'b1, 1'b0, 8'd99, 1'b0);
        chk("ovf_set", 32'(n_ovf), 1);
        chk("ovf_d", 32'(n_d), 4);
        chk("ovf_full", 32'(n_full), 1);

        // drain and underflow
        for (int i = 1; i <= 4; i++) begin
            n_cyc(1'b0, 1'b1, 8'd0, 1'b0);
            chk("drain_dout", 32'(n_dout), 32'(i));
            chk("drain_d", 32'(n_d), 32'(4 - i));
        end
        chk("drain_empty", 32'(n_empty), 1);
        chk("drain_udf0", 32'(n_udf), 0);
        n_cyc(1'b0, 1'b1, 8'd0, 1'b0);
        chk("udf_set", 32'(n_udf), 1);
        chk("udf_dout_hold", 32'(n_dout), 4);
        chk("udf_d", 32'(n_d), 0);

        // clear errors, refill, then write+read while full
        n_cyc(1'b0, 1'b0, 8'd0, 1'b1);
        chk("sclr_ovf", 32'(n_ovf), 0);
        chk("sclr_udf", 32'(n_udf), 0);
        chk("sclr_dout", 32'(n_dout), 0);
        for (int i = 1; i <= 4; i++) n_cyc(1'b1, 1'b0, 8'(i), 1'b0);
        chk("refill_full", 32'(n_full), 1);
        n_cyc(1'b1, 1'b1, 8'd5, 1'b0);
        chk("fullrw_dout", 32'(n_dout), 1);
        chk("fullrw_d", 32'(n_d), 4);
        chk("fullrw_ovf", 32'(n_ovf), 0);
        for (int i = 2; i <= 5; i++) begin
            n_cyc(1'b0, 1'b1, 8'd0, 1'b0);
            chk("fullrw_drain", 32'(n_dout), 32'(i));
        end
        chk("fullrw_empty", 32'(n_empty), 1);

        // empty with write+read: only the write lands, no bypass
        n_cyc(1'b1, 1'b1, 8'd7, 1'b0);
        chk("emptyrw_d", 32'(n_d), 1);
        chk("emptyrw_udf", 32'(n_udf), 1);
        chk("emptyrw_nobypass", 32'(n_dout), 5);
        n_cyc(1'b0, 1'b1, 8'd0, 1'b0);
        chk("emptyrw_read", 32'(n_dout), 7);

        // build D=3 with ovf=1, then sclr together with a write
        for (int i = 11; i <= 14; i++) n_cyc(1'b1, 1'b0, 8'(i), 1'b0);
        n_cyc(1'b1, 1'b0, 8'd15, 1'b0);
        n_cyc(1'b0, 1'b1, 8'd0, 1'b0);
        chk("pre_clr_d", 32'(n_d), 3);
        chk("pre_clr_ovf", 32'(n_ovf), 1);
        chk("pre_clr_dout", 32'(n_dout), 11);
        n_cyc(1'b1, 1'b0, 8'd50, 1'b1);
        chk("clr_d", 32'(n_d), 0);
        chk("clr_empty", 32'(n_empty), 1);
        chk("clr_ovf", 32'(n_ovf), 0);
        chk("clr_udf", 32'(n_udf), 0);

        // show-ahead wrap with N=5, D kept at or below 3
        for (int c = 0; c < 13; c++) begin
            w = (c < 10);
            r = (c >= 3);
            nxt = 8'(100 + c);
            s_cyc(w, r, nxt);
            if (r && q.size() > 0) void'(q.pop_front());
            if (w) q.push_back(nxt);
            chk("sa_d", 32'(s_d), 32'(q.size()));
            chk("sa_empty", 32'(s_empty), (q.size() == 0) ? 1 : 0);
            if (q.size() > 0) chk("sa_head", 32'(s_dout), 32'(q[0]));
        end
        chk("sa_udf", 32'(s_udf), 0);
        chk("sa_ovf", 32'(s_ovf), 0);

        // refill to 2 and reset between edges
        n_cyc(1'b1, 1'b0, 8'd21, 1'b0);
        n_cyc(1'b1, 1'b0, 8'd22, 1'b0);
        chk("pre_rst_d", 32'(n_d), 2);
        #2;
        rst = 1'b0;
        #1;
        chk("async_rst_d", 32'(n_d), 0);
        chk("async_rst_empty", 32'(n_empty), 1);
        chk("async_rst_ae", 32'(n_ae), 1);
        chk("async_rst_full", 32'(n_full), 0);
        chk("async_rst_dout", 32'(n_dout), 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
